regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of reg_file (IN/INADDRESS/WRITE) in the RV32IM pipeline.

---
 rtl/rv32_pkg.sv | 13 +
 rtl/wb_scoreboard.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared constants and FSM encodings for the RV32IM register-file writeback path.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int REG_X0 = 0;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_B = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// MUL/DIV op is issued and cleared when its result is accepted for writeback.
module wb_scoreboard
  import rv32_pkg::*;
#(
  parameter int AW = rv32_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;

  // Next pending vector: clear first so a same-cycle set of the same index wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    pending_next = pending;
    if (clr_en) pending_next[clr_addr] = 1'b0;
    if (set_en) pending_next[set_addr] = 1'b1;
    pending_next[REG_X0] = 1'b0;
  end

  // Pending register; x0 can never be pending.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this vector is flops, not RAM, so it is reset: a hazard bit that
    // survived reset would stall ID on a write that will never arrive.
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Read ports show registered state only; an issue this cycle is visible next cycle.
  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];
  assign rd_busy  = pending[rd_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: arbitrates pipeline writeback (A, never
// stalls) against the MUL/DIV unit (B, valid/ready), forcing a one-cycle
// pipeline bubble when B has been denied too long.
module regfile_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int XLEN         = rv32_pkg::XLEN,
  parameter int AW           = rv32_pkg::AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            A_VALID,
  input  logic [AW-1:0]   A_ADDR,
  input  logic [XLEN-1:0] A_DATA,
  input  logic            B_VALID,
  input  logic [AW-1:0]   B_ADDR,
  input  logic [XLEN-1:0] B_DATA,
  output logic            B_READY,
  input  logic            ISSUE_VALID,
  input  logic [AW-1:0]   ISSUE_RD,
  input  logic [AW-1:0]   RS1_ADDR,
  input  logic [AW-1:0]   RS2_ADDR,
  output logic            RS1_BUSY,
  output logic            RS2_BUSY,
  output logic            RD_BUSY,
  output logic            STALL_PIPE,
  output logic            WB_WRITE,
  output logic [AW-1:0]   WB_ADDR,
  output logic [XLEN-1:0] WB_DATA,
  output logic            PROTO_ERR
);

  localparam int            CW       = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);
  localparam logic [AW-1:0] ADDR_X0  = AW'(REG_X0);

  arb_state_e    state;
  logic [CW-1:0] wait_cnt;
  logic          force_b;
  logic          grant_a;
  logic          grant_b;
  logic          b_denied;

  // In FORCE_B the pipeline is bubbled, so B owns the port even if A misbehaves.
  assign force_b  = (state == ST_FORCE_B);
  assign grant_b  = RESET & B_VALID & (force_b | ~A_VALID);
  assign grant_a  = A_VALID & ~force_b;
  assign b_denied = B_VALID & A_VALID & ~force_b;
  assign B_READY  = grant_b;

  wb_scoreboard #(.AW(AW)) u_scoreboard (
    .clk      (CLK),
    .rst_n    (RESET),
    .set_en   (ISSUE_VALID & (ISSUE_RD != ADDR_X0)),
    .set_addr (ISSUE_RD),
    .clr_en   (grant_b),
    .clr_addr (B_ADDR),
    .rs1_addr (RS1_ADDR),
    .rs2_addr (RS2_ADDR),
    .rd_addr  (ISSUE_RD),
    .rs1_busy (RS1_BUSY),
    .rs2_busy (RS2_BUSY),
    .rd_busy  (RD_BUSY)
  );

  // Write-port register: latch the granted request; writes to x0 are dropped.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: state updates use <= so every flop samples pre-edge values,
    // independent of statement order.
    if (!RESET) begin
      WB_WRITE <= 1'b0;
      WB_ADDR  <= '0;
      WB_DATA  <= '0;
    end else if (grant_b) begin
      WB_WRITE <= (B_ADDR != ADDR_X0);
      WB_ADDR  <= B_ADDR;
      WB_DATA  <= B_DATA;
    end else if (grant_a) begin
      WB_WRITE <= (A_ADDR != ADDR_X0);
      WB_ADDR  <= A_ADDR;
      WB_DATA  <= A_DATA;
    end else begin
      WB_WRITE <= 1'b0;
    end
  end

  // Starvation FSM: count consecutive denials of B, then bubble the pipeline for one cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_NORMAL;
      wait_cnt   <= '0;
      STALL_PIPE <= 1'b0;
      PROTO_ERR  <= 1'b0;
    end else begin
      case (state)
        ST_NORMAL: begin
          STALL_PIPE <= 1'b0;
          if (b_denied) begin
            if (wait_cnt == CNT_LAST) begin
              state      <= ST_FORCE_B;
              STALL_PIPE <= 1'b1;
              wait_cnt   <= '0;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_FORCE_B: begin
          // A request arriving during the bubble is lost; flag it permanently.
          STALL_PIPE <= 1'b0;
          wait_cnt   <= '0;
          state      <= ST_NORMAL;
          if (A_VALID) PROTO_ERR <= 1'b1;
        end
        default: begin
          state      <= ST_NORMAL;
          STALL_PIPE <= 1'b0;
          wait_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for single-cycle
// behaviour plus hand-written sequences for starvation, protocol error and reset.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_VALID, B_VALID, ISSUE_VALID;
  logic [4:0]  A_ADDR, B_ADDR, ISSUE_RD, RS1_ADDR, RS2_ADDR;
  logic [31:0] A_DATA, B_DATA;
  logic        B_READY, RS1_BUSY, RS2_BUSY, RD_BUSY, STALL_PIPE, WB_WRITE, PROTO_ERR;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .AW(5), .STARVE_LIMIT(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .A_VALID     (A_VALID),
    .A_ADDR      (A_ADDR),
    .A_DATA      (A_DATA),
    .B_VALID     (B_VALID),
    .B_ADDR      (B_ADDR),
    .B_DATA      (B_DATA),
    .B_READY     (B_READY),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_RD    (ISSUE_RD),
    .RS1_ADDR    (RS1_ADDR),
    .RS2_ADDR    (RS2_ADDR),
    .RS1_BUSY    (RS1_BUSY),
    .RS2_BUSY    (RS2_BUSY),
    .RD_BUSY     (RD_BUSY),
    .STALL_PIPE  (STALL_PIPE),
    .WB_WRITE    (WB_WRITE),
    .WB_ADDR     (WB_ADDR),
    .WB_DATA     (WB_DATA),
    .PROTO_ERR   (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_b_ready;
    logic        exp_rs1_busy;
    logic        exp_rs2_busy;
    logic        exp_rd_busy;
    logic        exp_wb_write;
    logic        chk_ad;
    logic [4:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic        exp_stall;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int av, input int aa, input int ad, input int bv, input int ba,
                         input int bd, input int iv, input int ir, input int r1, input int r2,
                         input int eb, input int e1, input int e2, input int ed, input int ew,
                         input int ca, input int ewa, input int ewd, input int es);
    vec_t v;
    v.a_valid      = av[0];
    v.a_addr       = aa[4:0];
    v.a_data       = ad;
    v.b_valid      = bv[0];
    v.b_addr       = ba[4:0];
    v.b_data       = bd;
    v.issue_valid  = iv[0];
    v.issue_rd     = ir[4:0];
    v.rs1          = r1[4:0];
    v.rs2          = r2[4:0];
    v.exp_b_ready  = eb[0];
    v.exp_rs1_busy = e1[0];
    v.exp_rs2_busy = e2[0];
    v.exp_rd_busy  = ed[0];
    v.exp_wb_write = ew[0];
    v.chk_ad       = ca[0];
    v.exp_wb_addr  = ewa[4:0];
    v.exp_wb_data  = ewd;
    v.exp_stall    = es[0];
    vq.push_back(v);
  endtask

  task automatic idle();
    A_VALID     = 1'b0;
    A_ADDR      = '0;
    A_DATA      = '0;
    B_VALID     = 1'b0;
    B_ADDR      = '0;
    B_DATA      = '0;
    ISSUE_VALID = 1'b0;
    ISSUE_RD    = '0;
    RS1_ADDR    = '0;
    RS2_ADDR    = '0;
  endtask

  task automatic drive_ab(input logic av, input int aa, input int ad,
                          input logic bv, input int ba, input int bd);
    A_VALID = av;
    A_ADDR  = aa[4:0];
    A_DATA  = ad;
    B_VALID = bv;
    B_ADDR  = ba[4:0];
    B_DATA  = bd;
  endtask

  task automatic check_wb(input string name, input logic w, input int a, input int d);
    check({name, ".wb_write"}, WB_WRITE, w);
    check({name, ".wb_addr"}, WB_ADDR, a[4:0]);
    check({name, ".wb_data"}, WB_DATA, d);
  endtask

  // Four cycles of A and B both valid; the fourth denial raises STALL_PIPE.
  task automatic starve_b(input string name, input int ba, input int bd);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive_ab(1'b1, 1, 'h100 + i, 1'b1, ba, bd);
      #1 check({name, ".denied_b_ready"}, B_READY, 1'b0);
      check({name, ".denied_stall_pre"}, STALL_PIPE, 1'b0);
      @(posedge CLK);
      #1 check_wb({name, ".a_wins"}, 1'b1, 1, 'h100 + i);
      check({name, ".stall"}, STALL_PIPE, (i == 3));
    end
  endtask

  initial begin
    // Reset state.
    RESET = 1'b0;
    idle();
    repeat (3) @(posedge CLK);
    #1;
    check("reset.wb_write", WB_WRITE, 1'b0);
    check("reset.wb_addr", WB_ADDR, 5'd0);
    check("reset.wb_data", WB_DATA, 32'd0);
    check("reset.stall", STALL_PIPE, 1'b0);
    check("reset.proto_err", PROTO_ERR, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    //       av aa ad     bv ba bd     iv ir r1 r2  eb e1 e2 ed  ew ca wa wd    st
    add_vec(1, 2, 95,    0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 2, 95,   0);
    add_vec(0, 0, 0,     0, 0, 0,     1, 4, 4, 0,  0, 0, 0, 0,  0, 1, 2, 95,   0);
    add_vec(0, 0, 0,     0, 0, 0,     0, 4, 4, 4,  0, 1, 1, 1,  0, 1, 2, 95,   0);
    add_vec(0, 0, 0,     1, 4, 6,     0, 0, 4, 0,  1, 1, 0, 0,  1, 1, 4, 6,    0);
    add_vec(0, 0, 0,     0, 0, 0,     0, 0, 4, 0,  0, 0, 0, 0,  0, 1, 4, 6,    0);
    add_vec(1, 0, 77,    0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,    0);
    add_vec(1, 3, 'h33,  1, 9, 'h99,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 3, 'h33, 0);
    add_vec(0, 0, 0,     1, 0, 5,     0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0,    0);
    add_vec(0, 0, 0,     1, 7, 'h70,  1, 7, 0, 0,  1, 0, 0, 0,  1, 1, 7, 'h70, 0);
    add_vec(0, 0, 0,     0, 0, 0,     0, 0, 7, 0,  0, 1, 0, 0,  0, 1, 7, 'h70, 0);
    add_vec(0, 0, 0,     0, 0, 0,     1, 0, 0, 7,  0, 0, 1, 0,  0, 1, 7, 'h70, 0);
    add_vec(0, 0, 0,     0, 0, 0,     0, 0, 0, 7,  0, 0, 1, 0,  0, 1, 7, 'h70, 0);
    add_vec(0, 0, 0,     1, 7, 'h71,  0, 0, 7, 0,  1, 1, 0, 0,  1, 1, 7, 'h71, 0);
    add_vec(0, 0, 0,     0, 0, 0,     0, 0, 7, 0,  0, 0, 0, 0,  0, 1, 7, 'h71, 0);

    foreach (vq[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      @(negedge CLK);
      drive_ab(vq[k].a_valid, vq[k].a_addr, vq[k].a_data,
               vq[k].b_valid, vq[k].b_addr, vq[k].b_data);
      ISSUE_VALID = vq[k].issue_valid;
      ISSUE_RD    = vq[k].issue_rd;
      RS1_ADDR    = vq[k].rs1;
      RS2_ADDR    = vq[k].rs2;
      #1;
      check({tag, ".b_ready"}, B_READY, vq[k].exp_b_ready);
      check({tag, ".rs1_busy"}, RS1_BUSY, vq[k].exp_rs1_busy);
      check({tag, ".rs2_busy"}, RS2_BUSY, vq[k].exp_rs2_busy);
      check({tag, ".rd_busy"}, RD_BUSY, vq[k].exp_rd_busy);
      @(posedge CLK);
      #1;
      check({tag, ".wb_write"}, WB_WRITE, vq[k].exp_wb_write);
      if (vq[k].chk_ad) begin
        check({tag, ".wb_addr"}, WB_ADDR, vq[k].exp_wb_addr);
        check({tag, ".wb_data"}, WB_DATA, vq[k].exp_wb_data);
      end
      check({tag, ".stall"}, STALL_PIPE, vq[k].exp_stall);
      check({tag, ".proto_err"}, PROTO_ERR, 1'b0);
    end

    // Starvation: pipeline obeys the bubble, B is served, then back to normal.
    @(negedge CLK);
    idle();
    starve_b("starve", 10, 'hAA);
    @(negedge CLK);
    drive_ab(1'b0, 0, 0, 1'b1, 10, 'hAA);
    #1 check("starve.forced_b_ready", B_READY, 1'b1);
    @(posedge CLK);
    #1 check_wb("starve.b_write", 1'b1, 10, 'hAA);
    check("starve.stall_clear", STALL_PIPE, 1'b0);
    check("starve.proto_err", PROTO_ERR, 1'b0);
    @(negedge CLK);
    drive_ab(1'b1, 12, 'hC0, 1'b1, 13, 'hD0);
    #1 check("starve.normal_again", B_READY, 1'b0);
    @(posedge CLK);
    #1 check_wb("starve.a_after", 1'b1, 12, 'hC0);
    @(negedge CLK);
    idle();
    @(posedge CLK);

    // Protocol error: A keeps driving during the bubble; B still wins and the flag sticks.
    starve_b("proto", 11, 'hBB);
    @(negedge CLK);
    drive_ab(1'b1, 1, 'h200, 1'b1, 11, 'hBB);
    #1 check("proto.b_ready", B_READY, 1'b1);
    @(posedge CLK);
    #1 check_wb("proto.b_write", 1'b1, 11, 'hBB);
    check("proto.err_set", PROTO_ERR, 1'b1);
    check("proto.stall_clear", STALL_PIPE, 1'b0);
    @(negedge CLK);
    idle();
    @(posedge CLK);
    #1 check("proto.err_sticky1", PROTO_ERR, 1'b1);
    @(negedge CLK);
    drive_ab(1'b1, 6, 'h66, 1'b0, 0, 0);
    @(posedge CLK);
    #1 check_wb("proto.a_write", 1'b1, 6, 'h66);
    check("proto.err_sticky2", PROTO_ERR, 1'b1);

    // Reset mid-run with pending[5] set and B waiting.
    @(negedge CLK);
    idle();
    ISSUE_VALID = 1'b1;
    ISSUE_RD    = 5'd5;
    @(negedge CLK);
    idle();
    RS1_ADDR = 5'd5;
    drive_ab(1'b1, 3, 1, 1'b1, 5, 'h55);
    #1 check("rst.pending5", RS1_BUSY, 1'b1);
    check("rst.b_denied", B_READY, 1'b0);
    #1 RESET = 1'b0;
    #1;
    check("rst.b_ready", B_READY, 1'b0);
    check("rst.rs1_busy", RS1_BUSY, 1'b0);
    check_wb("rst.async", 1'b0, 0, 0);
    check("rst.stall", STALL_PIPE, 1'b0);
    check("rst.proto_err", PROTO_ERR, 1'b0);
    @(negedge CLK);
    idle();
    RS1_ADDR = 5'd5;
    RESET    = 1'b1;
    @(posedge CLK);
    #1 check("rst.pending_gone", RS1_BUSY, 1'b0);
    check("rst.wb_idle", WB_WRITE, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
